// File: rtl/apb_spi_rx_read_handler_pkg.sv
// Shared definitions for the SPI receive-side APB read handler: register map,
// FSM state encoding and STATUS field layout.
package apb_rd_pkg;

  localparam int unsigned ADDR_RXDATA = 0;
  localparam int unsigned ADDR_STATUS = 1;

  // STATUS flags sit directly above the rx_level field, so offsets are relative to its width
  localparam int unsigned ST_EMPTY_OFS = 0;
  localparam int unsigned ST_FULL_OFS  = 1;
  localparam int unsigned ST_OVF_OFS   = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } rd_state_e;

endpackage

// File: rtl/apb_spi_rx_read_handler_fifo.sv
// Synchronous FIFO for received SPI words: power-of-two depth, wrapping pointers,
// occupancy counter. Pushes into a full FIFO are dropped unless a pop happens in the same cycle.
module sync_fifo
  import apb_rd_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [DATA_W-1:0]        wdata_i,
  output logic [DATA_W-1:0]        rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]    count_q, count_d;
  logic              push_ok, pop_ok;

  assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign pop_ok  = pop_i && !empty_o;
  assign push_ok = push_i && (!full_o || pop_ok);
  assign rdata_o = mem_q[rd_ptr_q];
  assign level_o = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + (PTR_W+1)'(1);
      2'b01:   count_d = count_q - (PTR_W+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset: emptying the pointers is enough to discard contents
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/apb_spi_rx_read_handler.sv
// APB read-path slave: pops received SPI words on RXDATA, reports STATUS, stalls on empty.
// Optional wait-state timeout enabled with `define APB_RD_TIMEOUT_EN.
module apb_spi_rx_read_handler
  import apb_rd_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int DEPTH   = 4,
  parameter int ADDR_W  = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                   PCLK,
  input  logic                   PRESET,
  input  logic                   PSEL,
  input  logic                   PENABLE,
  input  logic                   PWRITE,
  input  logic [ADDR_W-1:0]      PADDR,
  output logic [DATA_W-1:0]      PRDATA,
  output logic                   PREADY_R,
  output logic                   PSLVERR,
  input  logic [DATA_W-1:0]      APB_data_in,
  input  logic                   SPI_done,
  output logic [$clog2(DEPTH):0] rx_level
);

  localparam int LVL_W = $clog2(DEPTH) + 1;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT < 1 || DATA_W < LVL_W + 3)
  begin : g_bad_cfg
    $error("apb_spi_rx_read_handler: unsupported parameter set");
  end

  rd_state_e         state_q, state_d;
  logic [DATA_W-1:0] prdata_q, prdata_d;
  logic              pready_q, pready_d;
  logic              pslverr_q, pslverr_d;
  logic              ovf_q, ovf_d;
  logic              ovf_clr, ovf_set, pop;
  logic              rd_acc, is_rx, is_st;
  logic [DATA_W-1:0] fifo_rdata, status_w;
  logic              fifo_full, fifo_empty;
  logic [LVL_W-1:0]  fifo_level;

  sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
    .clk_i   (PCLK),
    .rst_i   (PRESET),
    .push_i  (SPI_done),
    .pop_i   (pop),
    .wdata_i (APB_data_in),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

  assign rd_acc  = PSEL && PENABLE && !PWRITE;
  assign is_rx   = (PADDR == ADDR_W'(ADDR_RXDATA));
  assign is_st   = (PADDR == ADDR_W'(ADDR_STATUS));
  assign ovf_set = SPI_done && fifo_full && !pop;

  always_comb begin
    status_w = '0;
    status_w[LVL_W-1:0]            = fifo_level;
    status_w[LVL_W + ST_EMPTY_OFS] = fifo_empty;
    status_w[LVL_W + ST_FULL_OFS]  = fifo_full;
    status_w[LVL_W + ST_OVF_OFS]   = ovf_q;
  end

`ifdef APB_RD_TIMEOUT_EN
  localparam int TMR_W = $clog2(TIMEOUT + 1);
  logic [TMR_W-1:0] timer_q, timer_d;
`endif

  always_comb begin
    state_d   = state_q;
    prdata_d  = prdata_q;
    pready_d  = 1'b0;
    pslverr_d = 1'b0;
    pop       = 1'b0;
    ovf_clr   = 1'b0;
`ifdef APB_RD_TIMEOUT_EN
    timer_d   = '0;
`endif
    case (state_q)
      IDLE: begin
        if (rd_acc) begin
          if (is_rx && fifo_empty) begin
            state_d = WAIT;
          end else begin
            state_d  = RESP;
            pready_d = 1'b1;
            if (is_rx) begin
              prdata_d = fifo_rdata;
              pop      = 1'b1;
            end else if (is_st) begin
              prdata_d = status_w;
              ovf_clr  = 1'b1;
            end else begin
              prdata_d  = '0;
              pslverr_d = 1'b1;
            end
          end
        end
      end
      WAIT: begin
        // Master abort: drop back without touching the FIFO
        if (!PSEL) begin
          state_d = IDLE;
        end else if (!fifo_empty) begin
          state_d  = RESP;
          pready_d = 1'b1;
          prdata_d = fifo_rdata;
          pop      = 1'b1;
        end
`ifdef APB_RD_TIMEOUT_EN
        else if (timer_q == TMR_W'(TIMEOUT - 1)) begin
          state_d   = RESP;
          pready_d  = 1'b1;
          prdata_d  = '0;
          pslverr_d = 1'b1;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
`endif
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // A new overflow in the same cycle as a STATUS read must not be lost
    ovf_d = ovf_q;
    if (ovf_clr) ovf_d = 1'b0;
    if (ovf_set) ovf_d = 1'b1;
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q   <= IDLE;
      prdata_q  <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      prdata_q  <= prdata_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      ovf_q     <= ovf_d;
    end
  end

`ifdef APB_RD_TIMEOUT_EN
  always_ff @(posedge PCLK) begin
    if (PRESET) timer_q <= '0;
    else        timer_q <= timer_d;
  end
`endif

  assign PRDATA   = prdata_q;
  assign PREADY_R = pready_q;
  assign PSLVERR  = pslverr_q;
  assign rx_level = fifo_level;

endmodule

// File: tb/tb_apb_spi_rx_read_handler.sv
// Directed bench for apb_spi_rx_read_handler at DATA_W=16, DEPTH=4, ADDR_W=4, TIMEOUT=64.
module tb_apb_spi_rx_read_handler;

  localparam int DATA_W  = 16;
  localparam int DEPTH   = 4;
  localparam int ADDR_W  = 4;
  localparam int TIMEOUT = 64;
  localparam int BOUND   = 200;

  logic              PCLK = 1'b0;
  logic              PRESET = 1'b1;
  logic              PSEL = 1'b0, PENABLE = 1'b0, PWRITE = 1'b0;
  logic [ADDR_W-1:0] PADDR = '0;
  logic [DATA_W-1:0] PRDATA;
  logic              PREADY_R, PSLVERR;
  logic [DATA_W-1:0] APB_data_in = '0;
  logic              SPI_done = 1'b0;
  logic [2:0]        rx_level;

  int n_tests = 0;
  int n_fail  = 0;

  apb_spi_rx_read_handler #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .PCLK(PCLK), .PRESET(PRESET), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PRDATA(PRDATA), .PREADY_R(PREADY_R), .PSLVERR(PSLVERR),
    .APB_data_in(APB_data_in), .SPI_done(SPI_done), .rx_level(rx_level)
  );

  always #5 PCLK = ~PCLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // STATUS = {zeros, overflow, full, empty, rx_level[2:0]}
  function automatic logic [15:0] st(input logic ovf, input logic full, input logic empty,
                                     input logic [2:0] lvl);
    return {10'b0, ovf, full, empty, lvl};
  endfunction

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  task automatic push(input logic [15:0] w);
    SPI_done = 1'b1;
    APB_data_in = w;
    tick();
    SPI_done = 1'b0;
  endtask

  task automatic apb_read(input logic [3:0] addr, input logic push_en, input logic [15:0] push_word,
                          output logic [15:0] data, output logic err, output int waits);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = addr;
    tick();
    PENABLE = 1'b1;
    if (push_en) begin
      SPI_done = 1'b1;
      APB_data_in = push_word;
    end
    tick();
    SPI_done = 1'b0;
    waits = 0;
    while (!PREADY_R && waits < BOUND) begin
      waits++;
      tick();
    end
    data = PRDATA;
    err  = PSLVERR;
    PSEL = 1'b0; PENABLE = 1'b0;
    tick();
  endtask

  task automatic rd(input string tag, input logic [3:0] addr, input logic [15:0] exp_d,
                    input logic exp_e);
    logic [15:0] d;
    logic        e;
    int          w;
    apb_read(addr, 1'b0, 16'h0, d, e, w);
    chk({tag, "_lat"}, 32'(w), 32'd0);
    chk({tag, "_data"}, 32'(d), 32'(exp_d));
    chk({tag, "_err"}, 32'(e), 32'(exp_e));
  endtask

  logic [15:0] d;
  logic        e, acc;
  int          w;

  initial begin
    // Reset
    tick(); tick();
    chk("rst_prdata", 32'(PRDATA), 32'd0);
    chk("rst_pready", 32'(PREADY_R), 32'd0);
    chk("rst_pslverr", 32'(PSLVERR), 32'd0);
    chk("rst_level", 32'(rx_level), 32'd0);
    PRESET = 1'b0;
    tick();

    // T1: two words in order
    push(16'hA5A5); push(16'h1234);
    chk("t1_level2", 32'(rx_level), 32'd2);
    rd("t1_rd0", 4'h0, 16'hA5A5, 1'b0);
    chk("t1_level1", 32'(rx_level), 32'd1);
    rd("t1_rd1", 4'h0, 16'h1234, 1'b0);
    chk("t1_level0", 32'(rx_level), 32'd0);
    tick(); tick(); tick();
    chk("t1_hold", 32'(PRDATA), 32'h1234);

    // T2: empty read stalls until a word arrives 5 cycles into WAIT
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 4'h0;
    tick();
    PENABLE = 1'b1;
    tick();
    acc = PREADY_R;
    repeat (4) begin tick(); acc |= PREADY_R; end
    SPI_done = 1'b1; APB_data_in = 16'hBEEF;
    tick();
    SPI_done = 1'b0;
    acc |= PREADY_R;
    chk("t2_stall", 32'(acc), 32'd0);
    chk("t2_prdata_held", 32'(PRDATA), 32'h1234);
    tick();
    chk("t2_ready", 32'(PREADY_R), 32'd1);
    chk("t2_data", 32'(PRDATA), 32'hBEEF);
    chk("t2_err", 32'(PSLVERR), 32'd0);
    chk("t2_level", 32'(rx_level), 32'd0);
    PSEL = 1'b0; PENABLE = 1'b0;
    tick();
    chk("t2_ready_1cyc", 32'(PREADY_R), 32'd0);

    // T3: overflow on the fifth push, cleared by the STATUS read
    push(16'h0011); push(16'h0022); push(16'h0033); push(16'h0044); push(16'h0055);
    chk("t3_level", 32'(rx_level), 32'd4);
    rd("t3_st0", 4'h1, st(1'b1, 1'b1, 1'b0, 3'd4), 1'b0);
    rd("t3_st1", 4'h1, st(1'b0, 1'b1, 1'b0, 3'd4), 1'b0);
    rd("t3_rx0", 4'h0, 16'h0011, 1'b0);
    rd("t3_rx1", 4'h0, 16'h0022, 1'b0);
    rd("t3_rx2", 4'h0, 16'h0033, 1'b0);
    rd("t3_rx3", 4'h0, 16'h0044, 1'b0);
    rd("t3_st2", 4'h1, st(1'b0, 1'b0, 1'b1, 3'd0), 1'b0);

    // Overflow set on the same edge as a STATUS read: old value returned, flag survives
    push(16'h0061); push(16'h0062); push(16'h0063); push(16'h0064);
    apb_read(4'h1, 1'b1, 16'h0065, d, e, w);
    chk("t3b_st_old", 32'(d), 32'(st(1'b0, 1'b1, 1'b0, 3'd4)));
    rd("t3b_st_set", 4'h1, st(1'b1, 1'b1, 1'b0, 3'd4), 1'b0);
    rd("t3b_st_clr", 4'h1, st(1'b0, 1'b1, 1'b0, 3'd4), 1'b0);
    rd("t3b_rx0", 4'h0, 16'h0061, 1'b0);
    rd("t3b_rx1", 4'h0, 16'h0062, 1'b0);
    rd("t3b_rx2", 4'h0, 16'h0063, 1'b0);
    rd("t3b_rx3", 4'h0, 16'h0064, 1'b0);

    // T4: push coincident with pop keeps the level
    push(16'h0101); push(16'h0202);
    apb_read(4'h0, 1'b1, 16'h0303, d, e, w);
    chk("t4_data", 32'(d), 32'h0101);
    chk("t4_level", 32'(rx_level), 32'd2);
    rd("t4_st", 4'h1, st(1'b0, 1'b0, 1'b0, 3'd2), 1'b0);
    rd("t4_rx0", 4'h0, 16'h0202, 1'b0);
    rd("t4_rx1", 4'h0, 16'h0303, 1'b0);

    // T5: unmapped address
    rd("t5_unmapped", 4'h7, 16'h0000, 1'b1);
    chk("t5_err_clr", 32'(PSLVERR), 32'd0);
`ifdef APB_RD_TIMEOUT_EN
    apb_read(4'h0, 1'b0, 16'h0, d, e, w);
    chk("t5_to_waits", 32'(w), 32'(TIMEOUT));
    chk("t5_to_err", 32'(e), 32'd1);
    chk("t5_to_data", 32'(d), 32'd0);
`endif

    // Master abort during WAIT: no pop, word stays queued
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 4'h0;
    tick();
    PENABLE = 1'b1;
    tick(); tick(); tick();
    PSEL = 1'b0; PENABLE = 1'b0;
    tick();
    push(16'h5A5A);
    acc = PREADY_R;
    tick(); acc |= PREADY_R;
    tick(); acc |= PREADY_R;
    chk("abort_no_ready", 32'(acc), 32'd0);
    chk("abort_level", 32'(rx_level), 32'd1);
    rd("abort_rx", 4'h0, 16'h5A5A, 1'b0);

    // T6: reset during WAIT
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 4'h0;
    tick();
    PENABLE = 1'b1;
    tick(); tick();
    PRESET = 1'b1; SPI_done = 1'b1; APB_data_in = 16'h7777;
    tick();
    SPI_done = 1'b0; PSEL = 1'b0; PENABLE = 1'b0;
    chk("t6_prdata", 32'(PRDATA), 32'd0);
    chk("t6_pready", 32'(PREADY_R), 32'd0);
    chk("t6_pslverr", 32'(PSLVERR), 32'd0);
    chk("t6_level", 32'(rx_level), 32'd0);
    PRESET = 1'b0;
    tick();
    push(16'h0A0A); push(16'h0B0B); push(16'h0C0C);
    chk("t6_level3", 32'(rx_level), 32'd3);
    PRESET = 1'b1;
    tick();
    PRESET = 1'b0;
    chk("t6_flush", 32'(rx_level), 32'd0);
    tick();
    rd("t6_st", 4'h1, st(1'b0, 1'b0, 1'b1, 3'd0), 1'b0);

    // Pending write access is never acknowledged and never pops
    push(16'h0D0D);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 4'h0;
    tick();
    PENABLE = 1'b1;
    acc = 1'b0;
    repeat (4) begin tick(); acc |= PREADY_R; end
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    tick();
    chk("t6_wr_no_ready", 32'(acc), 32'd0);
    chk("t6_wr_level", 32'(rx_level), 32'd1);
    rd("t6_wr_rx", 4'h0, 16'h0D0D, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, limit 200000 time units");
    $fatal(1, "global timeout");
  end

endmodule
